// File: rtl/cell_mem_arbiter.sv
// Arbiter for the single-port 1-bit cell RAM: display reads, a clear sweep and ant accesses.
// Priority is display > clear > ant; a 2-stage tag pipeline routes read data back.
module cell_mem_arbiter #(
  parameter int unsigned C_NUM_OF_CELLS_X = 5,
  parameter int unsigned C_NUM_OF_CELLS_Y = 5
) (
  input  logic        iclk,
  input  logic        irst,
  input  logic        iclear,
  output logic        oclear_busy,
  input  logic        idisp_req,
  input  logic [15:0] idisp_addr,
  output logic        odisp_valid,
  output logic        odisp_data,
  input  logic        iant_req,
  input  logic        iant_we,
  input  logic [15:0] iant_addr,
  input  logic        iant_wdata,
  output logic        oant_gnt,
  output logic        oant_rvalid,
  output logic        oant_rdata,
  output logic [15:0] omem_addr,
  output logic        omem_we,
  output logic        omem_wdata,
  input  logic        imem_rdata
);

  localparam int unsigned C_N    = C_NUM_OF_CELLS_X * C_NUM_OF_CELLS_Y;
  localparam logic [15:0] C_LAST = 16'(C_N - 1);

  typedef enum logic {ST_IDLE, ST_SWEEP} clr_state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_ANT, TAG_OOR} tag_t;

  clr_state_t  r_state;
  logic [15:0] r_cnt;
  tag_t        r_tag0;
  tag_t        r_tag1;

  logic w_sweep;
  logic w_ant_gnt;
  logic w_ant_in_range;

  always_comb begin
    w_sweep        = (r_state == ST_SWEEP);
    w_ant_in_range = (32'(iant_addr) < C_N);
    // Gated by reset so a request seen while in reset is never reported as taken.
    w_ant_gnt      = iant_req & ~idisp_req & ~w_sweep & ~irst;
  end

  assign oant_gnt    = w_ant_gnt;
  assign oclear_busy = w_sweep;

  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_tag0      <= TAG_NONE;
      r_tag1      <= TAG_NONE;
      omem_addr   <= '0;
      omem_we     <= 1'b0;
      omem_wdata  <= 1'b0;
      odisp_valid <= 1'b0;
      odisp_data  <= 1'b0;
      oant_rvalid <= 1'b0;
      oant_rdata  <= 1'b0;
    end else begin
      r_tag1      <= r_tag0;
      odisp_valid <= (r_tag1 == TAG_DISP);
      odisp_data  <= (r_tag1 == TAG_DISP) & imem_rdata;
      oant_rvalid <= (r_tag1 == TAG_ANT) | (r_tag1 == TAG_OOR);
      oant_rdata  <= (r_tag1 == TAG_ANT) & imem_rdata;

      omem_we <= 1'b0;
      r_tag0  <= TAG_NONE;
      if (idisp_req) begin
        omem_addr <= idisp_addr;
        r_tag0    <= TAG_DISP;
      end else if (w_sweep) begin
        omem_addr  <= r_cnt;
        omem_we    <= 1'b1;
        omem_wdata <= 1'b0;
        r_cnt      <= r_cnt + 16'd1;
        if (r_cnt == C_LAST) r_state <= ST_IDLE;
      end else if (w_ant_gnt) begin
        // Out-of-range ant accesses never reach the RAM; reads still return a zero.
        if (!w_ant_in_range) begin
          r_tag0 <= iant_we ? TAG_NONE : TAG_OOR;
        end else begin
          omem_addr <= iant_addr;
          if (iant_we) begin
            omem_we    <= 1'b1;
            omem_wdata <= iant_wdata;
          end else begin
            r_tag0 <= TAG_ANT;
          end
        end
      end

      if (!w_sweep && iclear) begin
        r_state <= ST_SWEEP;
        r_cnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_cell_mem_arbiter.sv
// Bench for cell_mem_arbiter: behavioural RAM, reference cell model and scoreboard queues
// for display reads, ant reads and RAM writes, driven by vector tables and sequences.
module tb_cell_mem_arbiter;

  localparam int unsigned X = 5;
  localparam int unsigned Y = 5;
  localparam int unsigned N = X * Y;

  logic        iclk = 1'b0;
  logic        irst = 1'b1;
  logic        iclear = 1'b0;
  logic        oclear_busy;
  logic        idisp_req = 1'b0;
  logic [15:0] idisp_addr = '0;
  logic        odisp_valid;
  logic        odisp_data;
  logic        iant_req = 1'b0;
  logic        iant_we = 1'b0;
  logic [15:0] iant_addr = '0;
  logic        iant_wdata = 1'b0;
  logic        oant_gnt;
  logic        oant_rvalid;
  logic        oant_rdata;
  logic [15:0] omem_addr;
  logic        omem_we;
  logic        omem_wdata;
  logic        imem_rdata = 1'b0;

  cell_mem_arbiter #(.C_NUM_OF_CELLS_X(X), .C_NUM_OF_CELLS_Y(Y)) dut (
    .iclk(iclk), .irst(irst), .iclear(iclear), .oclear_busy(oclear_busy),
    .idisp_req(idisp_req), .idisp_addr(idisp_addr), .odisp_valid(odisp_valid),
    .odisp_data(odisp_data), .iant_req(iant_req), .iant_we(iant_we),
    .iant_addr(iant_addr), .iant_wdata(iant_wdata), .oant_gnt(oant_gnt),
    .oant_rvalid(oant_rvalid), .oant_rdata(oant_rdata), .omem_addr(omem_addr),
    .omem_we(omem_we), .omem_wdata(omem_wdata), .imem_rdata(imem_rdata)
  );

  always #5 iclk = ~iclk;

  logic ram [0:N-1];
  always @(posedge iclk) begin
    if (32'(omem_addr) < N) begin
      if (omem_we) ram[omem_addr] <= omem_wdata;
      imem_rdata <= ram[omem_addr];
    end else begin
      imem_rdata <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge iclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct { logic data; int due; } rd_t;
  typedef struct { logic [15:0] addr; logic data; int due; } wr_t;
  rd_t disp_q[$];
  rd_t ant_q[$];
  wr_t wr_q[$];

  // Reference model state
  logic golden [0:N-1];
  logic m_sweep = 1'b0;
  int   m_cnt = 0;
  int   busy_cnt = 0;
  int   k_disp = 0;

  always @(negedge iclk) begin
    rd_t e;
    wr_t w;
    if (!irst) begin
      if (odisp_valid) begin
        if (disp_q.size() == 0) chk("disp_unexpected", 1, 0);
        else begin
          e = disp_q.pop_front();
          chk("disp_data", 32'(odisp_data), 32'(e.data));
          chk("disp_cycle", cyc, e.due);
        end
      end else if (disp_q.size() > 0 && disp_q[0].due <= cyc) begin
        e = disp_q.pop_front();
        chk("disp_missing", 0, 1);
      end
      if (oant_rvalid) begin
        if (ant_q.size() == 0) chk("ant_unexpected", 1, 0);
        else begin
          e = ant_q.pop_front();
          chk("ant_rdata", 32'(oant_rdata), 32'(e.data));
          chk("ant_cycle", cyc, e.due);
        end
      end else if (ant_q.size() > 0 && ant_q[0].due <= cyc) begin
        e = ant_q.pop_front();
        chk("ant_missing", 0, 1);
      end
      if (omem_we) begin
        if (wr_q.size() == 0) chk("wr_unexpected", 32'(omem_addr), 32'hFFFF);
        else begin
          w = wr_q.pop_front();
          chk("wr_addr", 32'(omem_addr), 32'(w.addr));
          chk("wr_data", 32'(omem_wdata), 32'(w.data));
          chk("wr_cycle", cyc, w.due);
        end
      end else if (wr_q.size() > 0 && wr_q[0].due <= cyc) begin
        w = wr_q.pop_front();
        chk("wr_missing", 32'(w.addr), 32'hFFFF);
      end
    end
  end

  // One cycle of stimulus; called at negedge+1, returns at the next negedge+1.
  task automatic step(input logic clr, input logic dr, input logic [15:0] da,
                      input logic ar, input logic aw, input logic [15:0] aa, input logic ad,
                      input logic use_tbl, input logic tbl_gnt);
    logic sb, g;
    rd_t e;
    wr_t w;
    iclear = clr; idisp_req = dr; idisp_addr = da;
    iant_req = ar; iant_we = aw; iant_addr = aa; iant_wdata = ad;
    #1;
    sb = m_sweep;
    g  = ar & ~dr & ~sb;
    chk("ant_gnt", 32'(oant_gnt), 32'(g));
    if (use_tbl) chk("ant_gnt_tbl", 32'(oant_gnt), 32'(tbl_gnt));
    chk("clear_busy", 32'(oclear_busy), 32'(sb));
    if (oclear_busy) busy_cnt++;
    if (dr && sb) k_disp++;
    if (dr) begin
      e.data = golden[da]; e.due = cyc + 3; disp_q.push_back(e);
    end else if (sb) begin
      w.addr = 16'(m_cnt); w.data = 1'b0; w.due = cyc + 1; wr_q.push_back(w);
      golden[m_cnt] = 1'b0;
      m_cnt++;
      if (m_cnt == N) m_sweep = 1'b0;
    end else if (g) begin
      if (aw) begin
        if (32'(aa) < N) begin
          w.addr = aa; w.data = ad; w.due = cyc + 1; wr_q.push_back(w);
          golden[aa] = ad;
        end
      end else begin
        e.data = (32'(aa) < N) ? golden[aa] : 1'b0; e.due = cyc + 3; ant_q.push_back(e);
      end
    end
    if (clr && !sb) begin m_sweep = 1'b1; m_cnt = 0; end
    @(negedge iclk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Backdoor preload of the bench RAM: 0 = pattern (i%4==1), 1 = all ones
  task automatic preload(input int mode);
    for (int i = 0; i < int'(N); i++) begin
      ram[i]    = (mode == 1) ? 1'b1 : ((i % 4) == 1);
      golden[i] = ram[i];
    end
  endtask

  typedef struct {
    logic clr; logic dr; logic [15:0] da;
    logic ar; logic aw; logic [15:0] aa; logic ad;
    logic gnt;
  } vec_t;
  vec_t vecs[13];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g10;
    //           clr   dr    da      ar    aw    aa      ad    gnt
    vecs[0]  = '{1'b0, 1'b1, 16'd7,  1'b1, 1'b1, 16'd7,  1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b1, 16'd7,  1'b1, 1'b1};
    vecs[2]  = '{1'b0, 1'b1, 16'd7,  1'b0, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b1, 16'd12, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd12, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd30, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b1, 16'd30, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 16'd1,  1'b0, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 16'd12, 1'b1, 1'b0, 16'd5,  1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 16'd0,  1'b1, 1'b0, 16'd5,  1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 16'd0,  1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 16'd0,  1'b0, 1'b0, 16'd0,  1'b0, 1'b0};

    preload(0);
    @(negedge iclk); #1;
    @(negedge iclk); #1;
    chk("rst_omem_we", 32'(omem_we), 0);
    chk("rst_omem_addr", 32'(omem_addr), 0);
    chk("rst_omem_wdata", 32'(omem_wdata), 0);
    chk("rst_odisp_valid", 32'(odisp_valid), 0);
    chk("rst_oant_rvalid", 32'(oant_rvalid), 0);
    chk("rst_oclear_busy", 32'(oclear_busy), 0);
    irst = 1'b0;
    idle(2);

    // Collision and ant access vectors
    for (int i = 0; i < 13; i++)
      step(vecs[i].clr, vecs[i].dr, vecs[i].da, vecs[i].ar, vecs[i].aw,
           vecs[i].aa, vecs[i].ad, 1'b1, vecs[i].gnt);

    // Display stream with ant held off, then the pending ant write is taken
    for (int i = 0; i < int'(N); i++) step(0, 1, 16'(i), 1, 1, 16'd3, 0, 1'b1, 1'b0);
    step(0, 0, 0, 1, 1, 16'd3, 0, 1'b1, 1'b1);
    idle(5);

    // Clear with alternate display reads, second iclear ignored, ant blocked throughout
    preload(1);
    busy_cnt = 0; k_disp = 0;
    step(1, 0, 0, 1, 0, 16'd0, 0, 1'b1, 1'b1);
    for (int i = 0; i < 100 && m_sweep; i++)
      step(i == 6, (i % 2) == 1, 16'((i * 7) % N), 1, 0, 16'd0, 0, 1'b1, 1'b0);
    chk("clear_ended", 32'(m_sweep), 0);
    step(0, 0, 0, 1, 0, 16'd0, 0, 1'b1, 1'b1);
    chk("clear_busy_len", busy_cnt, 25 + k_disp);
    idle(4);
    for (int i = 0; i < int'(N); i++) step(0, 1, 16'(i), 0, 0, 0, 0, 0, 0);
    idle(5);

    // Reset in the cycle the sweep's write to address 10 is on the RAM port
    preload(1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(10);
    step(0, 1, 16'd20, 0, 0, 0, 0, 0, 0);
    g10 = golden[10];
    idle(1);
    iclear = 0; idisp_req = 0; iant_req = 0;
    irst = 1'b1;
    #1;
    chk("arst_clear_busy", 32'(oclear_busy), 0);
    chk("arst_omem_we", 32'(omem_we), 0);
    chk("arst_odisp_valid", 32'(odisp_valid), 0);
    chk("arst_oant_rvalid", 32'(oant_rvalid), 0);
    disp_q.delete(); ant_q.delete(); wr_q.delete();
    m_sweep = 1'b0; m_cnt = 0; golden[10] = g10;
    @(negedge iclk); #1;
    irst = 1'b0;
    idle(3);
    for (int i = 0; i < int'(N); i++) step(0, 1, 16'(i), 0, 0, 0, 0, 0, 0);
    idle(6);

    chk("disp_q_drained", disp_q.size(), 0);
    chk("ant_q_drained", ant_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cell_mem_arbiter.md
# cell_mem_arbiter

Shares the single-port 1-bit cell RAM between the display scanner, the ant logic FSM and an internal clear engine. Sits between those requesters and the RAM, and is the only block driving the RAM address/write port. Display reads have fixed latency and top priority; the clear engine sweeps all X*Y cells to white on request; the ant FSM gets the leftover slots through a req/gnt handshake.

## Interface
Parameters:
- C_NUM_OF_CELLS_X, 5, cells per line
- C_NUM_OF_CELLS_Y, 5, lines; N = X*Y cells, N ≤ 65536

Ports:
- iclk  in  1  clock
- irst  in  1  asynchronous, active-high reset
- iclear  in  1  one-cycle pulse: start clear sweep
- oclear_busy  out  1  clear sweep in progress
- idisp_req  in  1  display read request, may be asserted every cycle
- idisp_addr  in  16  display read address
- odisp_valid  out  1  display read data valid
- odisp_data  out  1  display read data
- iant_req  in  1  ant access request, held until granted
- iant_we  in  1  1 = write, 0 = read
- iant_addr  in  16  ant address
- iant_wdata  in  1  ant write data
- oant_gnt  out  1  combinational accept, same cycle as request
- oant_rvalid  out  1  ant read data valid
- oant_rdata  out  1  ant read data
- omem_addr  out  16  RAM address, registered
- omem_we  out  1  RAM write enable, registered
- omem_wdata  out  1  RAM write data, registered
- imem_rdata  in  1  RAM read data, 1-cycle synchronous read

## Operation
- One RAM slot per cycle. Priority, evaluated each cycle T: display > clear > ant.
- Display: idisp_req=1 always wins the slot; read issued with tag DISP.
- Clear engine, states IDLE/SWEEP:
  - IDLE: iclear=1 loads counter=0 and enters SWEEP. oclear_busy=1 from the next cycle.
  - SWEEP: in any cycle without idisp_req, it issues a write of 0 to address counter and increments the counter.
  - After issuing address N-1 it returns to IDLE; oclear_busy=0 in the following cycle.
  - iclear while in SWEEP is ignored; the sweep is not restarted.
- Ant: oant_gnt = iant_req & ~idisp_req & ~(state==SWEEP).
  - On gnt, the request is consumed that cycle. The ant must deassert or change iant_req/addr in the next cycle, or a new request is taken.
  - Writes with iant_addr ≥ N are granted but dropped: no omem_we. Reads with iant_addr ≥ N are granted and return oant_rdata=0 with oant_rvalid.
- Idle slot: omem_we=0; omem_addr holds its previous value.
- Read return path: a 2-stage tag pipeline (DISP/ANT/OOR/NONE) aligned to the RAM latency routes imem_rdata to the display or ant output register.
- Order: same-cycle display read and ant write to one address: the display read is issued first and returns the old value. The ant write lands in a later slot.

## Timing
- Request in cycle T → omem_addr/omem_we/omem_wdata driven in T+1 → imem_rdata valid in T+2 → odisp_valid/odisp_data or oant_rvalid/oant_rdata registered, high for exactly one cycle in T+3. Read latency is 3 cycles, independent of contention.
- Write issued in T is visible to a read issued in T+1 or later.
- Back-to-back display reads give back-to-back valids, one per cycle.
- Clear duration: N cycles plus the number of display-request cycles during the sweep.
- Reset (irst=1, asynchronous): all outputs 0, counter 0, clear state IDLE, tag pipeline NONE.
  - Reset mid-sweep aborts the sweep; cells not yet written keep their contents.
  - Reset discards any in-flight read returns.

## Test plan
- Reset mid-sweep with X=Y=5: iclear, then irst at sweep cycle 10 → oclear_busy=0, omem_we=0, odisp_valid=0 and oant_rvalid=0 asynchronously. Addresses 0–9 are 0; 10–24 are unchanged.
- Display stream: idisp_req=1 with addresses 0..24 on consecutive cycles → odisp_valid high for 25 consecutive cycles starting 3 cycles after the first request. Data matches RAM contents in order. oant_gnt=0 throughout despite iant_req=1.
- Collision: cell 7 = 0. Same cycle: display read addr 7, ant write addr 7 data 1 → display returns 0; oant_gnt=0 that cycle and 1 the next. A display read of 7 issued two cycles later returns 1.
- Clear with interleaving: all cells set to 1, iclear, then display requests on alternate cycles → exactly 25 writes of 0 to addresses 0..24, in order. oclear_busy stays high 25+k cycles, where k = display cycles. A second iclear mid-sweep has no effect.
- Ant access: write 1 to addr 12 → gnt same cycle. Read addr 12 → oant_rvalid/oant_rdata=1 three cycles later. Read addr 30 (≥N) → oant_rdata=0 with valid. Write addr 30 → no omem_we.
- Ant blocked by clear: iant_req=1 throughout a sweep → oant_gnt=0 until the cycle after oclear_busy falls, then 1.
